// File: rtl/gemm_mac_unit.sv
// gemm_mac_unit: 2x2 x 2x2 signed int8 matrix multiply / multiply-accumulate.
// One MAC per cycle over 8 cycles; results are committed only when a command
// finishes, so the result port never exposes partial sums.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   gemm_valid      command strobe; accepted while idle or in the done cycle
//   gemm_rdata1/2   matrix A / B, element (r,t) at bits [8*(2r+t) +: 8]
//   gemm_acc        1: C += A*B, 0: C = A*B (sampled with the command)
//   gemm_done       1 when able to accept a command
//   gemm_irq        one-cycle pulse on completion
//   gemm_ovr        sticky: command seen while busy; cleared on next accept
//   gemm_sat        (GEMM_MAC_SATURATE_EN only) any MAC of the command saturated
//   res_sel         result index 2*r+col
//   res_data        committed C[res_sel], sign-extended from ACC_W
//
// Build option: define GEMM_MAC_SATURATE_EN for saturating accumulation and the
// gemm_sat output; otherwise accumulation wraps modulo 2^ACC_W.
module gemm_mac_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gemm_valid,
  input  logic [31:0] gemm_rdata1,
  input  logic [31:0] gemm_rdata2,
  input  logic        gemm_acc,
  output logic        gemm_done,
  output logic        gemm_irq,
  output logic        gemm_ovr,
`ifdef GEMM_MAC_SATURATE_EN
  output logic        gemm_sat,
`endif
  input  logic [1:0]  res_sel,
  output logic [31:0] res_data
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                   state_q, state_d;
  logic [2:0]               k_q, k_d;
  logic [31:0]              a_q, a_d, b_q, b_d;
  logic signed [ACC_W-1:0]  w_q [4];
  logic signed [ACC_W-1:0]  w_d [4];
  logic signed [ACC_W-1:0]  c_q [4];
  logic signed [ACC_W-1:0]  c_d [4];
  logic                     done_q, done_d, irq_q, irq_d, ovr_q, ovr_d;

  // MAC datapath: k = {r, col, t}
  logic [1:0]                c_idx, a_idx, b_idx;
  logic signed [DATA_W-1:0]  a_el, b_el;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   mac_res;

  always_comb begin
    c_idx = {k_q[2], k_q[1]};
    a_idx = {k_q[2], k_q[0]};
    b_idx = {k_q[0], k_q[1]};
    a_el  = a_q[32'(a_idx) * DATA_W +: DATA_W];
    b_el  = b_q[32'(b_idx) * DATA_W +: DATA_W];
    prod  = a_el * b_el;
  end

`ifdef GEMM_MAC_SATURATE_EN
  logic                    sat_q, sat_d;
  logic                    mac_sat;
  logic signed [ACC_W:0]   sum_wide;

  // One guard bit: overflow shows as guard bit differing from the ACC_W sign bit.
  always_comb begin
    sum_wide = (ACC_W+1)'(w_q[c_idx]) + (ACC_W+1)'(prod);
    mac_sat  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (mac_sat) begin
      mac_res = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      mac_res = sum_wide[ACC_W-1:0];
    end
  end

  assign gemm_sat = sat_q;
`else
  always_comb begin
    mac_res = w_q[c_idx] + ACC_W'(prod);
  end
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = done_q;
    irq_d   = 1'b0;
    ovr_d   = ovr_q;
    for (int i = 0; i < 4; i++) begin
      w_d[i] = w_q[i];
      c_d[i] = c_q[i];
    end
`ifdef GEMM_MAC_SATURATE_EN
    sat_d = sat_q;
`endif

    case (state_q)
      StIdle, StDone: begin
        if (gemm_valid) begin
          a_d     = gemm_rdata1;
          b_d     = gemm_rdata2;
          ovr_d   = 1'b0;
          k_d     = 3'd0;
          state_d = StCalc;
          done_d  = 1'b0;
          for (int i = 0; i < 4; i++) begin
            w_d[i] = gemm_acc ? c_q[i] : '0;
          end
`ifdef GEMM_MAC_SATURATE_EN
          sat_d = 1'b0;
`endif
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StCalc: begin
        // Overrun: flag only, the running command is left untouched.
        if (gemm_valid) begin
          ovr_d = 1'b1;
        end
        w_d[c_idx] = mac_res;
        k_d        = k_q + 3'd1;
`ifdef GEMM_MAC_SATURATE_EN
        sat_d = sat_q | mac_sat;
`endif
        if (k_q == 3'd7) begin
          for (int i = 0; i < 4; i++) begin
            c_d[i] = w_d[i];
          end
          state_d = StDone;
          done_d  = 1'b1;
          irq_d   = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      k_q     <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b1;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        w_q[i] <= '0;
        c_q[i] <= '0;
      end
`ifdef GEMM_MAC_SATURATE_EN
      sat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < 4; i++) begin
        w_q[i] <= w_d[i];
        c_q[i] <= c_d[i];
      end
`ifdef GEMM_MAC_SATURATE_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign gemm_done = done_q;
  assign gemm_irq  = irq_q;
  assign gemm_ovr  = ovr_q;

  always_comb begin
    res_data = 32'(c_q[res_sel]);
  end

endmodule

// File: tb/tb_gemm_mac_unit.sv
// Scoreboard bench for gemm_mac_unit: ACC_W=32 and ACC_W=16 instances share stimulus.
// Expected results come from an arithmetic model of C = A*B (+C).
module tb_gemm_mac_unit;

  logic        clk, rst, gemm_valid, gemm_acc;
  logic [31:0] rdata1, rdata2;
  logic [1:0]  res_sel;
  logic        done32, irq32, ovr32, done16, irq16, ovr16;
  logic [31:0] res32, res16;
`ifdef GEMM_MAC_SATURATE_EN
  logic        sat32, sat16;
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0][31:0] r32;
    logic [3:0][31:0] r16;
    logic             ovr;
    logic             sat32;
    logic             sat16;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             it;
  logic [3:0][31:0] cur32, cur16;
  longint           mod32[4];
  longint           mod16[4];
  int               n_checks, n_pass, busy;

  gemm_mac_unit #(.DATA_W(8), .ACC_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .gemm_valid(gemm_valid), .gemm_rdata1(rdata1),
    .gemm_rdata2(rdata2), .gemm_acc(gemm_acc), .gemm_done(done32), .gemm_irq(irq32),
    .gemm_ovr(ovr32),
`ifdef GEMM_MAC_SATURATE_EN
    .gemm_sat(sat32),
`endif
    .res_sel(res_sel), .res_data(res32)
  );

  gemm_mac_unit #(.DATA_W(8), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .gemm_valid(gemm_valid), .gemm_rdata1(rdata1),
    .gemm_rdata2(rdata2), .gemm_acc(gemm_acc), .gemm_done(done16), .gemm_irq(irq16),
    .gemm_ovr(ovr16),
`ifdef GEMM_MAC_SATURATE_EN
    .gemm_sat(sat16),
`endif
    .res_sel(res_sel), .res_data(res16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  function automatic longint el(input logic [31:0] x, input int i);
    logic signed [7:0] e;
    e = x[i*8 +: 8];
    return e;
  endfunction

  function automatic longint wrapv(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r >= m / 2) r -= m;
    if (r < -(m / 2)) r += m;
    return r;
  endfunction

  // C[r][col] = (acc ? C : 0) + sum_t A[r][t]*B[t][col], t ascending, clamped per add if saturating.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit acc,
                                input int w, input bit sat, input longint old_c[4],
                                output longint new_c[4], output bit satf);
    longint hi, lo, v;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -hi - 1;
    satf = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int col = 0; col < 2; col++) begin
        v = acc ? old_c[2*r+col] : 0;
        for (int t = 0; t < 2; t++) begin
          v += el(a, 2*r+t) * el(b, 2*t+col);
          if (sat && v > hi) begin v = hi; satf = 1'b1; end
          if (sat && v < lo) begin v = lo; satf = 1'b1; end
        end
        new_c[2*r+col] = sat ? v : wrapv(v, w);
      end
    end
  endfunction

  // Monitor: pops on completion, checks every result index every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      cur32 = '0;
      cur16 = '0;
      busy  = 0;
    end else begin
      chk("irq_match", {31'b0, irq16}, {31'b0, irq32});
      chk("done_match", {31'b0, done16}, {31'b0, done32});
      if (irq32) begin
        chk("done_at_irq", {31'b0, done32}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("irq_expected", 32'd0, 32'd1);
        end else begin
          it    = exp_q.pop_front();
          cur32 = it.r32;
          cur16 = it.r16;
          chk("ovr32", {31'b0, ovr32}, {31'b0, it.ovr});
          chk("ovr16", {31'b0, ovr16}, {31'b0, it.ovr});
`ifdef GEMM_MAC_SATURATE_EN
          chk("sat32", {31'b0, sat32}, {31'b0, it.sat32});
          chk("sat16", {31'b0, sat16}, {31'b0, it.sat16});
`endif
        end
      end
      if (!done32) begin
        busy++;
      end else if (busy != 0) begin
        chk("busy_cycles", busy, 32'd8);
        busy = 0;
      end
      for (int s = 0; s < 4; s++) begin
        res_sel = 2'(s);
        #1;
        chk($sformatf("res32_c%0d", s), res32, cur32[s]);
        chk($sformatf("res16_c%0d", s), res16, cur16[s]);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit acc,
                       input int ovr_n);
    longint n32[4];
    longint n16[4];
    bit     s32, s16;
    exp_t   e;
    int     waited;
    waited = 0;
    @(negedge clk);
    while (done32 !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (done32 !== 1'b1) chk("ready_timeout", {31'b0, done32}, 32'd1);
    model(a, b, acc, 32, SatEn, mod32, n32, s32);
    model(a, b, acc, 16, SatEn, mod16, n16, s16);
    for (int i = 0; i < 4; i++) begin
      e.r32[i] = 32'(n32[i]);
      e.r16[i] = 32'(n16[i]);
      mod32[i] = n32[i];
      mod16[i] = n16[i];
    end
    e.ovr   = (ovr_n > 0);
    e.sat32 = s32;
    e.sat16 = s16;
    exp_q.push_back(e);
    gemm_valid = 1'b1;
    rdata1     = a;
    rdata2     = b;
    gemm_acc   = acc;
    @(posedge clk);
    #1;
    gemm_valid = 1'b0;
    rdata1     = $urandom;
    rdata2     = $urandom;
    gemm_acc   = 1'($urandom_range(0, 1));
    if (ovr_n > 0) begin
      repeat (ovr_n - 1) @(posedge clk);
      #1 gemm_valid = 1'b1;
      @(posedge clk);
      #1 gemm_valid = 1'b0;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    busy       = 0;
    rst        = 1'b0;
    gemm_valid = 1'b0;
    gemm_acc   = 1'b0;
    rdata1     = '0;
    rdata2     = '0;
    res_sel    = '0;
    cur32      = '0;
    cur16      = '0;
    for (int i = 0; i < 4; i++) begin
      mod32[i] = 0;
      mod16[i] = 0;
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("rst_done", {31'b0, done32}, 32'd1);
    chk("rst_irq", {31'b0, irq32}, 32'd0);
    chk("rst_ovr", {31'b0, ovr32}, 32'd0);

    // Basic multiply, accumulate, signed with overrun, ovr clear, 16-bit overflow.
    issue(32'h04030201, 32'h08070605, 1'b0, 0);
    issue(32'h04030201, 32'h08070605, 1'b1, 0);
    issue(32'h000000FF, 32'h00000080, 1'b0, 3);
    issue(32'h04030201, 32'h08070605, 1'b0, 0);
    issue(32'h80808080, 32'h80808080, 1'b0, 0);
    issue(32'h80808080, 32'h80808080, 1'b1, 8);

    for (int n = 0; n < 30; n++) begin
      int gap, ov;
      gap = $urandom_range(0, 3);
      ov  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      repeat (gap) @(posedge clk);
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), ov);
    end

    // Abort mid-calculation: no commit, no irq, results cleared.
    issue($urandom, $urandom, 1'b1, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("abort_async_done", {31'b0, done32}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      mod32[i] = 0;
      mod16[i] = 0;
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("abort_done", {31'b0, done32}, 32'd1);
    chk("abort_irq", {31'b0, irq32}, 32'd0);
    chk("abort_ovr", {31'b0, ovr16}, 32'd0);

    issue(32'h04030201, 32'h08070605, 1'b1, 0);
    issue($urandom, $urandom, 1'b1, 2);

    repeat (15) @(negedge clk);
    chk("pending_irqs", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gemm_mac_unit.md
Name: gemm_mac_unit

Overview:
- Small GEMM accelerator directly downstream of the core's GEMM command port.
- Consumes the core's gemm_valid/gemm_rdata1/gemm_rdata2 command and returns gemm_done to the core's stall logic.
- Each command computes a signed 2x2 x 2x2 int8 matrix product C = A*B, or accumulates into it (C += A*B), using one MAC per cycle.
- The core reads committed results back through an indexed result port.

Parameters:
- DATA_W, 8: element width, signed two's complement; 4 elements are packed per 32-bit operand word.
- ACC_W, 32: accumulator width; legal range 16..32.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- gemm_valid  input  1  command strobe from core
- gemm_rdata1  input  32  matrix A: [7:0]=A00 [15:8]=A01 [23:16]=A10 [31:24]=A11
- gemm_rdata2  input  32  matrix B: same packing as A
- gemm_acc  input  1  sampled with command; 1 = C += A*B, 0 = C = A*B
- gemm_done  output  1  1 = idle / able to accept a command; 0 = busy
- gemm_irq  output  1  one-cycle pulse when a command completes
- gemm_ovr  output  1  sticky: a command arrived while busy
- res_sel  input  2  result index c = 2*r+col (C00, C01, C10, C11)
- res_data  output  32  committed C[res_sel], sign-extended from ACC_W

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, gemm_done=1, gemm_irq=0, gemm_ovr=0.
  - Working accumulators, committed results, latched operands and counter all clear to 0.
  - Reset asserted mid-CALC aborts the command; no commit and no irq.
- State IDLE:
  - gemm_valid=1 at a posedge: latch A, B and gemm_acc; clear gemm_ovr.
  - Working accumulators load committed C if gemm_acc=1, otherwise load 0.
  - k<=0; go to CALC; gemm_done=0 from that edge.
- State CALC, k = 0..7, one MAC per cycle:
  - r=k[2], col=k[1], t=k[0].
  - W[2r+col] += sext(A[r][t]) * sext(B[t][col]).
  - Product is a 2*DATA_W-bit signed value, sign-extended to ACC_W; the sum wraps modulo 2^ACC_W unless the optional feature is enabled.
  - At k=7: apply the final MAC, copy all four W values into the committed registers, go to DONE.
- State DONE (1 cycle):
  - gemm_irq=1, gemm_done=1; go to IDLE.
  - gemm_valid seen in DONE is accepted exactly as in IDLE (back-to-back commands allowed).
- Busy and latency:
  - gemm_done is 0 for exactly 8 cycles after the accepting edge.
  - New results are visible on res_data in the first cycle that gemm_done=1.
- gemm_valid while CALC:
  - Command is ignored; operands and accumulators are untouched.
  - gemm_ovr<=1 and stays set until the next accepted command.
- res_data:
  - Combinational mux of the committed registers.
  - During CALC it returns the previous command's results, never partial sums.
- gemm_valid held high continuously: accepted once per IDLE/DONE entry, and counted as overrun while in CALC.

Optional Feature:
- Macro GEMM_MAC_SATURATE_EN.
- Defined:
  - Each MAC add saturates to the ACC_W signed range: max 2^(ACC_W-1)-1, min -2^(ACC_W-1).
  - Committed values are saturated values.
  - Add 1-bit output gemm_sat: sticky per command, set if any MAC in that command saturated, cleared on the next accept.
- Undefined:
  - Two's complement wrap-around.
  - No gemm_sat port.

Test Plan:
- Reset then idle: rst=0 for 2 cycles then release -> gemm_done=1, gemm_irq=0, gemm_ovr=0, res_data=0 for every res_sel.
- Basic multiply:
  - Stimulus: rdata1=0x04030201, rdata2=0x08070605, acc=0.
  - Response: gemm_done=0 for 8 cycles, then 1 with a single gemm_irq pulse.
  - Response: res_sel 0..3 reads 19, 22, 43, 50.
- Accumulate:
  - Stimulus: repeat the same operands with acc=1.
  - Response: 38, 44, 86, 100.
  - Response: res_data still reads 19, 22, 43, 50 during CALC.
- Signed and overrun:
  - Stimulus: rdata1=0x000000FF, rdata2=0x00000080, acc=0; pulse gemm_valid again at busy cycle 3.
  - Response: C00=128, others 0, gemm_ovr=1, still exactly one irq.
  - Response: next accepted command clears gemm_ovr.
- Back-to-back and reset abort:
  - Stimulus: gemm_valid in the DONE cycle.
  - Response: accepted immediately; gemm_done=0 on the next cycle.
  - Stimulus: rst low at CALC cycle 4.
  - Response: gemm_done=1, all results 0, no irq.
- ACC_W=16, all A and B elements = -128 (0x80808080), acc=0:
  - With GEMM_MAC_SATURATE_EN: all C=32767, gemm_sat=1.
  - Without: all C=-32768 (res_data 0xFFFF8000).
